tcdm_rr_arbiter: RTL and testbench

TCDM_RR_ARBITER -- requirements
Module: tcdm_rr_arbiter

---
 rtl/tcdm_arb_pkg.sv | 15 +
 rtl/tcdm_arb_idfifo.sv | 43 ++++
 rtl/tcdm_rr_arbiter.sv | 97 +++++++++
 tb/tb_tcdm_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_arb_pkg.sv
// tcdm_arb_pkg: shared defaults and request/response types for the TCDM round-robin arbiter
package tcdm_arb_pkg;
  localparam int NR_DEF = 2;
  localparam int MAX_OUTST_DEF = 2;
  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;
  typedef struct packed {
    logic [31:0] r_data;
    logic        r_valid;
  } tcdm_rsp_t;
endpackage

// File: rtl/tcdm_arb_idfifo.sv
// tcdm_arb_idfifo: in-order FIFO of granted requester indices awaiting a memory response
module tcdm_arb_idfifo
  import tcdm_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF,
  parameter int WIDTH = 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  assign rdata = mem_q[rd_q];
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q <= nxt(wr_q);
      end
      if (pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/tcdm_rr_arbiter.sv
// tcdm_rr_arbiter: round-robin NR:1 TCDM arbiter with zero-latency in-order response routing
// Define TCDM_ARB_PERF_EN to enable per-requester saturating grant/stall counters.
module tcdm_rr_arbiter
  import tcdm_arb_pkg::*;
#(
  parameter int NR = NR_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NR-1:0]        s_req_i,
  output logic [NR-1:0]        s_gnt_o,
  output logic [NR-1:0]        s_r_valid_o,
  input  logic [NR-1:0][31:0]  s_add_i,
  input  logic [NR-1:0][31:0]  s_data_i,
  output logic [NR-1:0][31:0]  s_r_data_o,
  input  logic [NR-1:0]        s_wen_i,
  input  logic [NR-1:0][3:0]   s_be_i,
  output logic                 m_req_o,
  output logic [31:0]          m_add_o,
  output logic                 m_wen_o,
  output logic [3:0]           m_be_o,
  output logic [31:0]          m_data_o,
  input  logic                 m_gnt_i,
  input  logic                 m_r_valid_i,
  input  logic [31:0]          m_r_data_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [NR-1:0][31:0]  perf_gnt_o,
  output logic [NR-1:0][31:0]  perf_stall_o
);
  localparam int IW = NR > 1 ? $clog2(NR) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);
  logic [IW-1:0] ptr_q, win, head;
  logic [CW-1:0] cnt;
  logic empty, hs, pop, err_q;
  tcdm_req_t win_req;
  tcdm_rsp_t rsp;
  // Scan from lowest to highest priority so the requester nearest ptr_q wins last.
  always_comb begin
    win = ptr_q;
    for (int i = NR - 1; i >= 0; i--) begin
      int j;
      j = (int'(ptr_q) + i) % NR;
      if (s_req_i[j]) win = IW'(j);
    end
  end
  assign win_req = '{add: s_add_i[win], wen: s_wen_i[win], be: s_be_i[win], data: s_data_i[win]};
  assign rsp = '{r_data: m_r_data_i, r_valid: m_r_valid_i};
  assign m_req_o = rst_ni & (|s_req_i) & (cnt < CW'(MAX_OUTST));
  assign {m_add_o, m_wen_o, m_be_o, m_data_o} = rst_ni ? win_req : '0;
  assign hs = m_req_o & m_gnt_i;
  assign pop = rst_ni & rsp.r_valid & ~empty;
  assign s_gnt_o = NR'(hs) << win;
  assign s_r_valid_o = NR'(pop) << head;
  assign busy_o = cnt != '0;
  assign err_o = err_q;
  always_comb begin
    s_r_data_o = '0;
    for (int i = 0; i < NR; i++) s_r_data_o[i] = s_r_valid_o[i] ? rsp.r_data : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (hs) ptr_q <= (int'(win) == NR - 1) ? '0 : win + IW'(1);
      if (rsp.r_valid && empty) err_q <= 1'b1;
    end
  end
  tcdm_arb_idfifo #(.DEPTH(MAX_OUTST), .WIDTH(IW)) u_idfifo (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .push  (hs),
    .wdata (win),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (cnt)
  );
`ifdef TCDM_ARB_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_gnt_o <= '0;
      perf_stall_o <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (s_gnt_o[i] && !(&perf_gnt_o[i])) perf_gnt_o[i] <= perf_gnt_o[i] + 32'd1;
        if (s_req_i[i] && !s_gnt_o[i] && !(&perf_stall_o[i])) perf_stall_o[i] <= perf_stall_o[i] + 32'd1;
      end
    end
  end
`else
  assign perf_gnt_o = '0;
  assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// tb_tcdm_rr_arbiter: directed scenarios with a response scoreboard and a latency-configurable memory model
module tb_tcdm_rr_arbiter;
  localparam int NR = 2;
`ifdef TCDM_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  logic [NR-1:0] s_req = '0;
  logic [NR-1:0] s_wen = '0;
  logic [NR-1:0][31:0] s_add = '0;
  logic [NR-1:0][31:0] s_data = '0;
  logic [NR-1:0][3:0] s_be = '0;
  logic [NR-1:0] s_gnt, s_rv;
  logic [NR-1:0][31:0] s_rdata, perf_gnt, perf_stall;
  logic m_req, m_wen, busy, err;
  logic [31:0] m_add, m_data;
  logic [3:0] m_be;
  logic m_gnt = 1'b1;
  logic m_rv = 1'b0;
  logic [31:0] m_rdata = '0;
  typedef struct { int id; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [31:0] data; } pend_t;
  exp_t exp_q[$];
  pend_t pend_q[$];
  int checks = 0, fails = 0, cyc = 0, lat = 1;
  bit inj = 1'b0;

  always #5 clk = ~clk;

  tcdm_rr_arbiter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .s_req_i(s_req), .s_gnt_o(s_gnt), .s_r_valid_o(s_rv),
    .s_add_i(s_add), .s_data_i(s_data), .s_r_data_o(s_rdata),
    .s_wen_i(s_wen), .s_be_i(s_be),
    .m_req_o(m_req), .m_add_o(m_add), .m_wen_o(m_wen), .m_be_o(m_be), .m_data_o(m_data),
    .m_gnt_i(m_gnt), .m_r_valid_i(m_rv), .m_r_data_i(m_rdata),
    .busy_o(busy), .err_o(err),
    .perf_gnt_o(perf_gnt), .perf_stall_o(perf_stall)
  );

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    return {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0;
    exp_q.delete();
    tick;
    tick;
    rst_ni = 1'b1;
  endtask

  // Memory: always grants, returns resp_of(addr) lat cycles after each handshake.
  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      if (m_req && m_gnt) pend_q.push_back('{due: cyc + lat, data: resp_of(m_add)});
      @(posedge clk);
      #1;
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        m_rv = 1'b1;
        m_rdata = p.data;
      end else begin
        m_rv = inj;
        m_rdata = inj ? 32'hDEAD_BEEF : '0;
        inj = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (s_rv != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rsp_unexpected: r_valid=%b with nothing outstanding", s_rv);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(s_rv), 32'(1 << e.id));
        chk("rsp_data", s_rdata[e.id], e.data);
        chk("rsp_other_data", s_rdata[1 - e.id], 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    rst_ni = 1'b0;
    s_req = 2'b01;
    @(negedge clk);
    chk("rst_m_req", m_req, 0);
    chk("rst_gnt", s_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_m_add", m_add, 0);
    tick;
    rst_ni = 1'b1;
    // single requester, 1-cycle memory
    lat = 1;
    s_add[0] = 32'h0011_0000;
    s_wen[0] = 1'b1;
    s_be[0] = 4'hF;
    s_req = 2'b01;
    exp_q.push_back('{id: 0, data: 32'h0000_0011});
    @(negedge clk);
    chk("single_m_req", m_req, 1);
    chk("single_gnt", s_gnt, 2'b01);
    chk("single_m_add", m_add, 32'h0011_0000);
    chk("single_m_wen", m_wen, 1);
    chk("single_busy_pre", busy, 0);
    tick;
    s_req = 2'b00;
    @(negedge clk);
    chk("single_busy", busy, 1);
    chk("single_rv", s_rv, 2'b01);
    tick;
    @(negedge clk);
    chk("single_busy_post", busy, 0);
    chk("single_drained", exp_q.size(), 0);
    tick;
    // both requesting continuously
    do_reset;
    s_add[0] = 32'h0000_1000;
    s_add[1] = 32'h0000_2000;
    s_wen = 2'b11;
    s_req = 2'b11;
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back('{id: k % 2, data: (k % 2 != 0) ? 32'h2000_0000 : 32'h1000_0000});
      @(negedge clk);
      chk("alt_gnt", s_gnt, (k % 2 != 0) ? 2'b10 : 2'b01);
      chk("perf_gnt0", perf_gnt[0], PERF ? (k + 1) / 2 : 0);
      chk("perf_gnt1", perf_gnt[1], PERF ? k / 2 : 0);
      chk("perf_stall0", perf_stall[0], PERF ? k / 2 : 0);
      chk("perf_stall1", perf_stall[1], PERF ? (k + 1) / 2 : 0);
      tick;
    end
    s_req = 2'b00;
    @(negedge clk);
    chk("perf_gnt0_end", perf_gnt[0], PERF ? 4 : 0);
    chk("perf_gnt1_end", perf_gnt[1], PERF ? 4 : 0);
    chk("perf_stall0_end", perf_stall[0], PERF ? 4 : 0);
    chk("perf_stall1_end", perf_stall[1], PERF ? 4 : 0);
    tick;
    tick;
    // outstanding limit with 3-cycle memory
    do_reset;
    lat = 3;
    s_add[0] = 32'h0000_3000;
    s_wen[0] = 1'b1;
    s_add[1] = 32'h0000_4000;
    s_wen[1] = 1'b0;
    s_data[1] = 32'hCAFE_F00D;
    s_be[1] = 4'h3;
    s_req = 2'b11;
    exp_q.push_back('{id: 0, data: 32'h3000_0000});
    exp_q.push_back('{id: 1, data: 32'h4000_0000});
    exp_q.push_back('{id: 0, data: 32'h3000_0000});
    @(negedge clk);
    chk("ost_gnt_c1", s_gnt, 2'b01);
    tick;
    @(negedge clk);
    chk("ost_gnt_c2", s_gnt, 2'b10);
    chk("ost_m_wen", m_wen, 0);
    chk("ost_m_data", m_data, 32'hCAFE_F00D);
    chk("ost_m_be", m_be, 4'h3);
    tick;
    @(negedge clk);
    chk("ost_full_m_req", m_req, 0);
    chk("ost_full_gnt", s_gnt, 0);
    chk("ost_full_busy", busy, 1);
    tick;
    @(negedge clk);
    chk("ost_full_pop_m_req", m_req, 0);
    chk("ost_full_pop_rv", s_rv, 2'b01);
    tick;
    @(negedge clk);
    chk("ost_gnt_c5", s_gnt, 2'b01);
    tick;
    s_req = 2'b00;
    repeat (4) tick;
    @(negedge clk);
    chk("ost_busy_end", busy, 0);
    chk("ost_drained", exp_q.size(), 0);
    // response with nothing outstanding
    inj = 1'b1;
    tick;
    @(negedge clk);
    chk("orphan_rv", s_rv, 0);
    chk("orphan_rdata0", s_rdata[0], 0);
    chk("orphan_err_pre", err, 0);
    tick;
    @(negedge clk);
    chk("orphan_err", err, 1);
    repeat (3) tick;
    @(negedge clk);
    chk("orphan_err_held", err, 1);
    tick;
    // reset with two in flight
    do_reset;
    @(negedge clk);
    chk("rst2_err_cleared", err, 0);
    tick;
    s_req = 2'b01;
    tick;
    tick;
    rst_ni = 1'b0;
    s_req = 2'b11;
    @(negedge clk);
    chk("rst2_busy", busy, 0);
    chk("rst2_m_req", m_req, 0);
    chk("rst2_gnt", s_gnt, 0);
    tick;
    rst_ni = 1'b1;
    s_req = 2'b00;
    @(negedge clk);
    chk("rst2_late_rv", s_rv, 0);
    tick;
    @(negedge clk);
    chk("rst2_late_err", err, 1);
    chk("rst2_late_rv2", s_rv, 0);
    tick;
    s_req = 2'b11;
    exp_q.push_back('{id: 0, data: 32'h3000_0000});
    @(negedge clk);
    chk("rst2_ptr_zero", s_gnt, 2'b01);
    tick;
    s_req = 2'b00;
    repeat (4) tick;
    @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
